pipe_skid_stage: RTL and testbench

Elastic pipeline stage register with a valid/ready handshake on both sides and a two-entry skid buffer. It replaces fixed inter-stage latches wherever the downstream stage can stall, for example MEM back-pressure into EX/MEM or a multi-cycle unit in EX. The block accepts one word per cycle and presents it to the next stage one cycle later. Its upstream-facing ready is registered, so stall paths never chain combinationally across stages.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_skid_stage.sv | 122 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and stage bundle widths for the elastic pipeline stages.
// Stage state encoding is fixed at 2 bits so occupancy decodes directly from it.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   localparam int PIPE_IFID_W  = 71;
   localparam int PIPE_IDEX_W  = 158;
   localparam int PIPE_EXMEM_W = 146;

endpackage

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with a two-entry skid buffer; one-cycle latency, full throughput.
// in_ready is a pure decode of the state register, so out_ready never reaches it combinationally.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   input  logic             flush,
   output logic [1:0]       occupancy
);

   pipe_state_t      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q;
   logic             main_ld, skid_ld;
   logic             in_fire, out_fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
      end else if (main_ld) begin
         main_q <= main_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_q <= '0;
      end else if (skid_ld) begin
         skid_q <= in_data;
      end
   end

   always_comb begin
      state_d  = state_q;
      main_d   = main_q;
      main_ld  = 1'b0;
      skid_ld  = 1'b0;
      in_fire  = in_valid & in_ready;
      out_fire = out_valid & out_ready;
      // Flush beats every transfer; data registers keep stale words masked by out_valid.
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  main_ld = 1'b1;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d  = in_data;
                  main_ld = 1'b1;
               end else if (in_fire) begin
                  skid_ld = 1'b1;
                  state_d = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  main_ld = 1'b1;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      occupancy = 2'd0;
      unique case (state_q)
         EMPTY: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            occupancy = 2'd0;
         end
         ONE: begin
            in_ready  = 1'b1;
            out_valid = 1'b1;
            occupancy = 2'd1;
         end
         FULL: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            occupancy = 2'd2;
         end
         default: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            occupancy = 2'd0;
         end
      endcase
   end

   assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and scoreboard-checked bench for pipe_skid_stage at the widest stage bundle width.
module tb_pipe_skid_stage;
   import pipe_pkg::*;

   localparam int W = PIPE_IDEX_W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready = 1'b0;
   logic         flush = 1'b0;
   logic [1:0]   occupancy;

   int n_cmp = 0;
   int n_bad = 0;

   pipe_skid_stage #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .flush     (flush),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string name, input logic ov, input logic ir,
                               input logic [1:0] occ, input logic [W-1:0] dat, input logic chk_dat);
      n_cmp++;
      if (out_valid !== ov) begin
         n_bad++;
         $display("FAIL %s out_valid got %b want %b", name, out_valid, ov);
      end
      n_cmp++;
      if (in_ready !== ir) begin
         n_bad++;
         $display("FAIL %s in_ready got %b want %b", name, in_ready, ir);
      end
      n_cmp++;
      if (occupancy !== occ) begin
         n_bad++;
         $display("FAIL %s occupancy got %0d want %0d", name, occupancy, occ);
      end
      if (chk_dat) begin
         n_cmp++;
         if (out_data !== dat) begin
            n_bad++;
            $display("FAIL %s out_data got %h want %h", name, out_data, dat);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      expect_state("reset_hold", 1'b0, 1'b1, 2'd0, '0, 1'b1);
      tick();
      rst = 1'b0;
      expect_state("reset_release", 1'b0, 1'b1, 2'd0, '0, 1'b1);
   endtask

   task automatic test_flow();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = W'(8'h11);
      tick();
      expect_state("flow_11", 1'b1, 1'b1, 2'd1, W'(8'h11), 1'b1);
      in_data = W'(8'h22);
      tick();
      expect_state("flow_22", 1'b1, 1'b1, 2'd1, W'(8'h22), 1'b1);
      in_data = W'(8'h33);
      tick();
      expect_state("flow_33", 1'b1, 1'b1, 2'd1, W'(8'h33), 1'b1);
      in_valid = 1'b0;
      tick();
      expect_state("flow_drain", 1'b0, 1'b1, 2'd0, '0, 1'b0);
   endtask

   task automatic test_skid();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(8'hA0);
      tick();
      expect_state("skid_one", 1'b1, 1'b1, 2'd1, W'(8'hA0), 1'b1);
      in_data = W'(8'hA1);
      tick();
      expect_state("skid_full", 1'b1, 1'b0, 2'd2, W'(8'hA0), 1'b1);
      in_valid = 1'b0;
      tick();
      expect_state("skid_stall2", 1'b1, 1'b0, 2'd2, W'(8'hA0), 1'b1);
      out_ready = 1'b1;
      tick();
      expect_state("skid_drain_a1", 1'b1, 1'b1, 2'd1, W'(8'hA1), 1'b1);
      tick();
      expect_state("skid_empty", 1'b0, 1'b1, 2'd0, '0, 1'b0);
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(8'hB0);
      tick();
      in_data = W'(8'hB1);
      tick();
      expect_state("flush_pre_full", 1'b1, 1'b0, 2'd2, W'(8'hB0), 1'b1);
      flush   = 1'b1;
      in_data = W'(8'hB2);
      tick();
      expect_state("flush_full", 1'b0, 1'b1, 2'd0, '0, 1'b0);
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      expect_state("flush_no_b2", 1'b0, 1'b1, 2'd0, '0, 1'b0);
      // From ONE a real in_fire coincides with flush and must still be dropped.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(8'hB3);
      tick();
      flush   = 1'b1;
      in_data = W'(8'hB4);
      tick();
      expect_state("flush_one_infire", 1'b0, 1'b1, 2'd0, '0, 1'b0);
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      expect_state("flush_no_b4", 1'b0, 1'b1, 2'd0, '0, 1'b0);
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(8'hC0);
      tick();
      in_data = W'(8'hC1);
      tick();
      in_valid = 1'b0;
      expect_state("arst_pre_full", 1'b1, 1'b0, 2'd2, W'(8'hC0), 1'b1);
      #1;
      rst = 1'b1;
      #1;
      expect_state("arst_mid_cycle", 1'b0, 1'b1, 2'd0, '0, 1'b1);
      tick();
      rst = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(8'hD0);
      out_ready = 1'b1;
      tick();
      expect_state("arst_first_xfer", 1'b1, 1'b1, 2'd1, W'(8'hD0), 1'b1);
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_random_stress();
      logic [W-1:0] sb[$];
      logic         will_in, will_out;
      for (int c = 0; c < 4000; c++) begin
         if (!(in_valid && !in_ready)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = W'({$urandom, $urandom, $urandom, $urandom, $urandom});
         end
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         will_in  = in_valid && in_ready;
         will_out = out_valid && out_ready;
         if (will_out) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL stress_spurious cycle %0d out_data %h with empty scoreboard", c, out_data);
            end else begin
               if (out_data !== sb[0]) begin
                  n_bad++;
                  $display("FAIL stress_order cycle %0d got %h want %h", c, out_data, sb[0]);
               end
               void'(sb.pop_front());
            end
         end
         if (will_in) sb.push_back(in_data);
         tick();
         n_cmp++;
         if (occupancy !== 2'(sb.size()) || sb.size() > 2) begin
            n_bad++;
            $display("FAIL stress_occ cycle %0d got %0d want %0d", c, occupancy, sb.size());
         end
         n_cmp++;
         if (out_valid !== (sb.size() != 0)) begin
            n_bad++;
            $display("FAIL stress_valid cycle %0d got %b want %b", c, out_valid, sb.size() != 0);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (out_valid && out_ready && sb.size() != 0) begin
            n_cmp++;
            if (out_data !== sb[0]) begin
               n_bad++;
               $display("FAIL stress_tail got %h want %h", out_data, sb[0]);
            end
            void'(sb.pop_front());
         end
         tick();
      end
      n_cmp++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL stress_lost left %0d words, out_valid %b want 0 words and 0", sb.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_flow();
      test_skid();
      test_flush();
      test_async_reset();
      test_random_stress();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
